icache: RTL

//  Direct-mapped, one-word-per-frame instruction cache between the pipelined datapath's fetch

---
 rtl/icache.sv | 108 ++++++++++
 1 files changed

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-frame instruction cache
// Hits answer combinationally; misses run a single-word fill from the memory controller.
module icache #(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             flush,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state;
    logic [31:0]        miss_addr;
    logic [SETS-1:0]    valid;
    logic [TAG_W-1:0]   tags  [SETS];
    logic [31:0]        words [SETS];

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic [IDX_W-1:0]   miss_idx;
    logic               hit;
    logic               fill_done;

    assign req_tag  = imemaddr[31:2+IDX_W];
    assign req_idx  = imemaddr[2+IDX_W-1:2];
    assign miss_tag = miss_addr[31:2+IDX_W];
    assign miss_idx = miss_addr[2+IDX_W-1:2];

    assign hit       = (state == IDLE) && imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
    assign fill_done = (state == FILL) && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? words[req_idx] : 32'h0;
    assign iREN     = (state == FILL);
    assign iaddr    = miss_addr;

    // Flush wins over a completing fill: the word lands but the frame stays invalid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= 32'h0;
            valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !hit) begin
                        state     <= FILL;
                        miss_addr <= {imemaddr[31:2], 2'b00};
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (flush) begin
                valid <= '0;
            end else if (fill_done) begin
                valid[miss_idx] <= 1'b1;
            end
        end
    end

    // Frame payload has no reset; validity alone decides whether it is used.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[miss_idx]  <= miss_tag;
            words[miss_idx] <= iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if ((state == IDLE) && imemREN && !hit && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule
